byte_frame_parser: RTL
======================

# byte_frame_parser

Downstream of the Manchester decoder in the serial receiver: consumes the decoded byte stream (`byte_in`/`byte_valid`) in the `clk_fast` domain. It hunts for a sync byte, reads a length byte, buffers the payload and checks a trailing CRC-8. Only CRC-clean frames are released as an AXI-Stream-style packet; bad frames are dropped and counted.

## Interface
- `SYNC_BYTE`, 8'hD5, frame start marker.
- `MAX_LEN`, 64, maximum payload bytes; also buffer depth (2..256).
- `TIMEOUT_CYCLES`, 1024, maximum idle `clk_fast` cycles between bytes inside a frame.

- `clk_fast`  in  1  receiver fast clock.
- `aresetn`  in  1  reset, synchronous, active-low; clock `clk_fast`.
- `byte_in`  in  8  decoded byte.
- `byte_valid`  in  1  1-cycle strobe qualifying `byte_in`; back-to-back strobes allowed.
- `m_tdata`  out  8  payload byte.
- `m_tvalid`  out  1  beat valid.
- `m_tready`  in  1  sink ready.
- `m_tlast`  out  1  last payload beat.
- `frame_ok`  out  1  1-cycle pulse: frame accepted into buffer.
- `frame_err`  out  1  1-cycle pulse: bad length, CRC mismatch or timeout.
- `err_cnt`  out  8  saturating count of `frame_err` pulses.
- `drop_cnt`  out  8  saturating count of bytes discarded while draining.

## Operation
- Frame format: SYNC, LEN, LEN payload bytes, CRC. CRC-8 uses poly 0x07, init 0x00, no reflection, no final xor. It covers LEN and the payload.
- FSM states: HUNT, LEN, PAYLOAD, CRC, DRAIN.
- HUNT: a byte equal to `SYNC_BYTE` moves to LEN. All other bytes are ignored without counting.
- LEN: LEN=0 or LEN>`MAX_LEN` pulses `frame_err` and returns to HUNT. Otherwise store LEN, seed CRC with LEN, reset the write pointer, go to PAYLOAD.
- PAYLOAD: write each byte to buffer[wr_ptr] and update the CRC. After the LEN-th byte, go to CRC.
- CRC: a received byte equal to the computed CRC pulses `frame_ok` and enters DRAIN. A mismatch pulses `frame_err` and goes to HUNT.
- DRAIN: stream buffer[0..LEN-1] out. Beat advances on `m_tvalid && m_tready`. `m_tlast`=1 only on beat LEN-1. After the last handshake, return to HUNT.
- DRAIN input handling: every `byte_valid` increments `drop_cnt`, saturating at 255. The byte is discarded, including SYNC.
- Timeout: an idle counter clears on every `byte_valid`. In LEN, PAYLOAD or CRC, reaching `TIMEOUT_CYCLES` pulses `frame_err` and returns to HUNT. No timeout applies in HUNT or DRAIN.
- `err_cnt` increments on each `frame_err` and saturates at 255.
- `m_tdata` and `m_tlast` hold stable while `m_tvalid && !m_tready`.

## Timing
- Reset values: state HUNT; `m_tvalid`, `m_tlast`, `frame_ok`, `frame_err` = 0; `m_tdata` = 0; `err_cnt`, `drop_cnt` = 0. Buffer contents are not reset.
- Reset mid-frame or mid-drain: the next cycle is HUNT with all outputs at reset values. The partial frame is lost and not counted.
- `frame_ok`/`frame_err` assert in the cycle after the deciding byte is sampled.
- The first `m_tvalid` asserts 2 cycles after the CRC byte is sampled (buffer read is registered).
- With `m_tready` held high, one beat is transferred per cycle.
- `m_tvalid` deasserts in the cycle after the `m_tlast` handshake. The parser accepts a new SYNC from that same cycle.
- CRC and length checks are combinational on the current byte, so back-to-back `byte_valid` never stalls the parser.

## Configuration
- `BYTE_FRAME_PARSER_CRC_EN` defined: the CRC byte is present and checked as above.
- Not defined: the frame has no CRC byte and the CRC state and logic are removed. After the LEN-th payload byte, `frame_ok` pulses and the parser enters DRAIN directly. A CRC mismatch can never occur; `frame_err` comes only from bad length or timeout.

## Test plan
- Good frame (CRC_EN): D5 01 00 15 with `m_tready`=1 -> `frame_ok` pulses once. One beat follows: `m_tdata`=00, `m_tlast`=1. `err_cnt`=0.
- Corrupt CRC: D5 01 00 16 -> `frame_err` pulses once, no `m_tvalid`, `err_cnt`=1, parser back in HUNT.
- Bad length and junk: 00 D5 00 and D5 41 (MAX_LEN=64) -> exactly 2 `frame_err` pulses, `err_cnt`=2, leading 00 ignored.
- Backpressure: a 4-byte frame 11 22 33 44 with `m_tready` toggling 1010… -> beats 11,22,33,44 in order. Data is held stable while stalled, and `m_tlast` appears only with 44.
- Drop and timeout: send 3 bytes during DRAIN with `m_tready`=0 -> `drop_cnt`=3. Then D5 02 AA followed by 1024 idle cycles -> `frame_err`, HUNT.
- Reset mid-payload: D5 04 01 02, assert `aresetn`=0 for 1 cycle, then a good frame -> only the good frame is output, `err_cnt`=0.

Source files
------------

// File: rtl/byte_frame_parser.sv
// Sync/length framed byte parser: buffers the payload, checks a trailing CRC-8 and
// releases clean frames as an AXI-Stream packet. BYTE_FRAME_PARSER_CRC_EN enables the CRC byte.
module byte_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hD5,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_fast,
  input  logic       aresetn,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic [7:0] drop_cnt
);

  localparam int PTR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [8:0]        MAX_LEN_9 = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
`ifdef BYTE_FRAME_PARSER_CRC_EN
    ST_CRC,
`endif
    ST_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         wr_ptr_q, wr_ptr_d;
  logic [7:0]         rd_ptr_q, rd_ptr_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [7:0]         m_tdata_q;
  logic               m_tvalid_q, m_tvalid_d;
  logic               m_tlast_q, m_tlast_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               wr_en;
  logic               rd_en;
  logic               in_frame;
  logic               len_bad;
  logic               timeout;

  logic [7:0] mem [MAX_LEN];

`ifdef BYTE_FRAME_PARSER_CRC_EN
  logic [7:0] crc_q, crc_d;

  // MSB-first CRC-8, poly 0x07, one whole byte per call
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
`else
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD);
`endif

  assign len_bad = (byte_in == 8'd0) || ({1'b0, byte_in} > MAX_LEN_9);
  assign timeout = in_frame && !byte_valid && (idle_q == IDLE_LAST);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idle_d      = idle_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
`ifdef BYTE_FRAME_PARSER_CRC_EN
    crc_d       = crc_q;
`endif

    if (byte_valid || !in_frame) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + IDLE_ONE;
    end

    case (state_q)
      ST_HUNT: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (byte_valid) begin
          if (len_bad) begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
          end else begin
            len_d    = byte_in;
            wr_ptr_d = 8'd0;
            state_d  = ST_PAYLOAD;
`ifdef BYTE_FRAME_PARSER_CRC_EN
            crc_d    = crc8_next(8'h00, byte_in);
`endif
          end
        end
      end

      ST_PAYLOAD: begin
        if (byte_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 8'd1;
`ifdef BYTE_FRAME_PARSER_CRC_EN
          crc_d    = crc8_next(crc_q, byte_in);
          if (wr_ptr_q == len_q - 8'd1) begin
            state_d = ST_CRC;
          end
`else
          if (wr_ptr_q == len_q - 8'd1) begin
            frame_ok_d = 1'b1;
            rd_ptr_d   = 8'd0;
            state_d    = ST_DRAIN;
          end
`endif
        end
      end

`ifdef BYTE_FRAME_PARSER_CRC_EN
      ST_CRC: begin
        if (byte_valid) begin
          if (byte_in == crc_q) begin
            frame_ok_d = 1'b1;
            rd_ptr_d   = 8'd0;
            state_d    = ST_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
          end
        end
      end
`endif

      ST_DRAIN: begin
        if (byte_valid && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
        // Output register refills whenever it is empty or being consumed
        if (!m_tvalid_q || m_tready) begin
          if (rd_ptr_q != len_q) begin
            rd_en      = 1'b1;
            m_tvalid_d = 1'b1;
            m_tlast_d  = (rd_ptr_q == len_q - 8'd1);
            rd_ptr_d   = rd_ptr_q + 8'd1;
          end else begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
          end
        end
        if (m_tvalid_q && m_tready && m_tlast_q) begin
          state_d = ST_HUNT;
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    if (timeout) begin
      frame_err_d = 1'b1;
      state_d     = ST_HUNT;
    end

    if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_fast) begin
    if (!aresetn) begin
      state_q     <= ST_HUNT;
      len_q       <= 8'd0;
      wr_ptr_q    <= 8'd0;
      rd_ptr_q    <= 8'd0;
      idle_q      <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
      drop_cnt_q  <= 8'd0;
`ifdef BYTE_FRAME_PARSER_CRC_EN
      crc_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idle_q      <= idle_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef BYTE_FRAME_PARSER_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // Payload buffer: plain write port, registered read feeding m_tdata directly
  always_ff @(posedge clk_fast) begin
    if (wr_en) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= byte_in;
    end
  end

  always_ff @(posedge clk_fast) begin
    if (!aresetn) begin
      m_tdata_q <= 8'd0;
    end else if (rd_en) begin
      m_tdata_q <= mem[rd_ptr_q[PTR_W-1:0]];
    end
  end

  assign m_tdata   = m_tdata_q;
  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
